i2s_audio_tx: RTL
=================

# i2s_audio_tx

- Audio output serializer between the NES core's APU sample output and the SGTL5000 codec's serial data input.
- Accepts 16-bit signed mono PCM samples through a valid/ready handshake and buffers them in a small FIFO.
- Shifts each sample out twice per frame (left, then right) in standard I2S format. SCLK and LRCLK are slaved to the codec-generated clocks.
- The toplevel routes its DOUT through the play-mode mux onto the codec DIN pin.

## Interface
Parameters:
- SAMPLE_W, 16, sample width in bits; also the number of data bits per channel slot.
- FIFO_DEPTH, 8, sample FIFO entries; must be a power of two and at least 2.

Ports:
- Clk  in  1  system clock (MCLK domain); must be at least 8x the SCLK frequency.
- Reset  in  1  asynchronous, active-high reset.
- sample_in  in  SAMPLE_W  signed PCM sample from the APU.
- sample_valid  in  1  sample_in is valid this cycle.
- sample_ready  out  1  FIFO can accept a sample; equals !full.
- SCLK  in  1  codec bit clock, asynchronous to Clk.
- LRCLK  in  1  codec word-select; low = left, high = right; asynchronous to Clk.
- DOUT  out  1  serial data to the codec.
- underrun  out  1  one-Clk pulse when a left-word load finds the FIFO empty.
- underrun_count  out  8  saturating count of underruns.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- **Synchronization:** SCLK and LRCLK each pass through an identical 2-FF synchronizer, then one edge-detect register.
  - sclk_fall = previous synced SCLK high and current synced SCLK low.
  - All serializer actions occur only in Clk cycles where sclk_fall = 1.
- **FIFO:**
  - Push when sample_valid && sample_ready.
  - Pop only at a left-word load.
  - A push and a pop in the same cycle are both honored; fifo_level is unchanged.
  - Full: sample_ready = 0, even if a pop occurs in the same cycle.
- **Word load:** on an sclk_fall where synced LRCLK differs from lr_prev:
  - Update lr_prev.
  - Set bit_cnt = SAMPLE_W.
  - Load shreg, choosing the value by new LRCLK level and FIFO state:
    - LRCLK low, FIFO non-empty: pop the FIFO head into hold_reg and shreg.
    - LRCLK low, FIFO empty: load hold_reg (repeat last sample); pulse underrun; increment underrun_count, saturating at 255.
    - LRCLK high: load hold_reg, so right equals left.
  - DOUT is not changed on the load edge (one-bit I2S delay).
- **Shift:** on an sclk_fall with no LRCLK change and bit_cnt > 0:
  - DOUT <= shreg[SAMPLE_W-1]; shreg <<= 1; bit_cnt--.
  - With bit_cnt = 0, DOUT <= 0 (pad bits until the next LRCLK change).
- **States:** IDLE, ACTIVE.
  - IDLE (after reset): DOUT held 0; right-channel LRCLK changes only update lr_prev.
  - The first LRCLK high→low change performs a left load and moves to ACTIVE. ACTIVE is never left except by Reset.
- **Reset** (asynchronous, at any point including mid-word):
  - DOUT = 0, sample_ready = 1, underrun = 0, underrun_count = 0, fifo_level = 0.
  - hold_reg = 0, shreg = 0, bit_cnt = 0, lr_prev = 0, synchronizers = 0, state IDLE.
  - FIFO contents are discarded.

## Timing
- DOUT updates 3 Clk cycles after the SCLK pin falls: 2 synchronizer stages, 1 edge detect, with DOUT registered in that third cycle. The codec samples DOUT on the following SCLK rise.
- The MSB appears on the second SCLK fall after the LRCLK transition. Bits go out MSB first over SAMPLE_W consecutive SCLK falls; the remaining slot bits are 0.
- sample_ready is combinational from registered FIFO pointers.
- A sample pushed in cycle t can be popped no earlier than cycle t+1.
- fifo_level and underrun_count are registered and update the cycle after the event.

## Structure
- Shared package nes_audio_pkg: SAMPLE_W default, audio_sample_t (logic signed [15:0]), I2S state enum.
- One sub-module, audio_sample_fifo: synchronous FIFO with parameterized width/depth, push/pop/full/empty/level ports.
- Synchronizers reuse the existing sync module; the edge detect and serializer are inline.

## Test plan
- **Basic frame:** push 0xA5C3; drive SCLK = 64·fs, LRCLK toggling every 32 SCLK, starting left. Required: left and right slots each carry 1010010111000011, MSB one SCLK after the LRCLK edge, then 16 zero bits.
- **Underrun:** push 0x1234, run 3 frames. Required:
  - Frames 2 and 3 repeat 0x1234.
  - underrun pulses exactly twice.
  - underrun_count = 2.
- **Full/backpressure:** hold sample_valid high with no SCLK. Required: sample_ready drops after 8 pushes and fifo_level = 8. Start clocks: one pop per frame; ready returns 1 Clk after the first pop; output order matches push order.
- **Startup alignment:** release reset while LRCLK is high. Required:
  - DOUT stays 0 through the partial right slot.
  - The first data appears in the left slot after the first high→low LRCLK transition.
- **Mid-word reset:** assert Reset after 5 bits of a left word. Required: DOUT = 0 and fifo_level = 0 immediately. After release, output resumes only from the next left slot with a newly pushed sample.
- **Saturation:** force 300 underruns. Required: underrun_count = 255 and holds.

Source files
------------

// File: rtl/nes_audio_pkg.sv
// rtl/nes_audio_pkg.sv - shared audio sample types, I2S state encoding and helpers
//
// Imported by the audio serializer and its FIFO. Holds the default sample
// width, the signed PCM sample type and the serializer state enum.

package nes_audio_pkg;

    localparam int SAMPLE_W_DEFAULT = 16;

    typedef logic signed [15:0] audio_sample_t;

    typedef enum logic {
        I2S_IDLE   = 1'b0,
        I2S_ACTIVE = 1'b1
    } i2s_state_t;

    // Saturating 8-bit increment used by event counters.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// rtl/audio_sample_fifo.sv - synchronous sample FIFO with occupancy count
//
// Ports:
//   clk, rst   system clock, asynchronous active-high reset
//   push       write push_data (ignored while full)
//   push_data  sample to store
//   pop        advance the read pointer (ignored while empty)
//   pop_data   current head entry, valid whenever empty = 0
//   full       level == DEPTH
//   empty      level == 0
//   level      registered occupancy, 0..DEPTH

module audio_sample_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (level == LW'(DEPTH));
    assign empty    = (level == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage is not reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/sync.sv
// rtl/sync.sv - two-flop synchronizer for asynchronous inputs
//
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset, clears both stages
//   d    asynchronous input
//   q    synchronized output, two clk cycles behind d

module sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/i2s_audio_tx.sv
// rtl/i2s_audio_tx.sv - I2S serializer from APU mono samples to codec DIN
//
// Ports:
//   Clk             system clock (MCLK domain), >= 8x SCLK
//   Reset           asynchronous active-high reset
//   sample_in       signed PCM sample from the APU
//   sample_valid    sample_in valid this cycle
//   sample_ready    FIFO can accept a sample (!full)
//   SCLK, LRCLK     codec bit clock and word select (low = left), async to Clk
//   DOUT            serial data to the codec, changes after SCLK falls
//   underrun        one-Clk pulse when a left load finds the FIFO empty
//   underrun_count  saturating underrun count
//   fifo_level      current FIFO occupancy

module i2s_audio_tx
    import nes_audio_pkg::*;
#(
    parameter int SAMPLE_W   = SAMPLE_W_DEFAULT,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic signed [SAMPLE_W-1:0]    sample_in,
    input  logic                          sample_valid,
    output logic                          sample_ready,
    input  logic                          SCLK,
    input  logic                          LRCLK,
    output logic                          DOUT,
    output logic                          underrun,
    output logic [7:0]                    underrun_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int CNT_W = $clog2(SAMPLE_W + 1);

    logic                sclk_s;
    logic                lrclk_s;
    logic                sclk_d;
    logic                sclk_fall;
    logic                lr_prev;
    logic                lr_change;

    i2s_state_t          state;
    i2s_state_t          state_next;
    logic                do_left;
    logic                do_right;
    logic                do_shift;

    logic [SAMPLE_W-1:0] shreg;
    logic [SAMPLE_W-1:0] hold_reg;
    logic [CNT_W-1:0]    bit_cnt;

    logic [SAMPLE_W-1:0] fifo_head;
    logic                fifo_full;
    logic                fifo_empty;

    sync #(.WIDTH(1)) u_sync_sclk (
        .clk (Clk),
        .rst (Reset),
        .d   (SCLK),
        .q   (sclk_s)
    );

    sync #(.WIDTH(1)) u_sync_lrclk (
        .clk (Clk),
        .rst (Reset),
        .d   (LRCLK),
        .q   (lrclk_s)
    );

    // Pops happen only on a left load; the FIFO itself ignores pops while empty.
    audio_sample_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (Clk),
        .rst       (Reset),
        .push      (sample_valid),
        .push_data (sample_in),
        .pop       (do_left),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign sample_ready = !fifo_full;
    assign sclk_fall    = sclk_d && !sclk_s;
    // lr_prev doubles as the LRCLK edge register, sampled only on SCLK falls.
    assign lr_change    = sclk_fall && (lrclk_s != lr_prev);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= I2S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Right-slot changes while idle only track lr_prev, so output always
    // starts on a full left slot.
    always_comb begin
        state_next = state;
        do_left    = 1'b0;
        do_right   = 1'b0;
        do_shift   = 1'b0;
        if (lr_change) begin
            if (!lrclk_s) begin
                do_left    = 1'b1;
                state_next = I2S_ACTIVE;
            end else if (state == I2S_ACTIVE) begin
                do_right = 1'b1;
            end
        end else if (sclk_fall && (state == I2S_ACTIVE)) begin
            do_shift = 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sclk_d         <= 1'b0;
            lr_prev        <= 1'b0;
            shreg          <= '0;
            hold_reg       <= '0;
            bit_cnt        <= '0;
            DOUT           <= 1'b0;
            underrun       <= 1'b0;
            underrun_count <= '0;
        end else begin
            sclk_d   <= sclk_s;
            underrun <= 1'b0;
            if (lr_change) begin
                lr_prev <= lrclk_s;
            end
            // DOUT is left alone on load edges: this gives the I2S one-bit delay.
            if (do_left) begin
                bit_cnt <= CNT_W'(SAMPLE_W);
                if (!fifo_empty) begin
                    hold_reg <= fifo_head;
                    shreg    <= fifo_head;
                end else begin
                    shreg          <= hold_reg;
                    underrun       <= 1'b1;
                    underrun_count <= sat_inc8(underrun_count);
                end
            end else if (do_right) begin
                bit_cnt <= CNT_W'(SAMPLE_W);
                shreg   <= hold_reg;
            end else if (do_shift) begin
                if (bit_cnt != '0) begin
                    DOUT    <= shreg[SAMPLE_W-1];
                    shreg   <= {shreg[SAMPLE_W-2:0], 1'b0};
                    bit_cnt <= bit_cnt - 1'b1;
                end else begin
                    DOUT <= 1'b0;
                end
            end
        end
    end

endmodule
